// File: rtl/chaos_if.sv
// Handshake/data bundle between the HPS chaos PIO bank and chaos_engine.
interface chaos_if;
  logic        chaos_reset;
  logic        chaos_step;
  logic [31:0] chaos_shift;
  logic        chaos_done;
  logic [12:0] chaos_temp;
  logic [31:0] chaos_w, chaos_x, chaos_y, chaos_z;

  modport master (output chaos_reset, chaos_step, chaos_shift,
                  input  chaos_done, chaos_temp, chaos_w, chaos_x, chaos_y, chaos_z);
  modport slave  (input  chaos_reset, chaos_step, chaos_shift,
                  output chaos_done, chaos_temp, chaos_w, chaos_x, chaos_y, chaos_z);
endinterface

// File: rtl/chaos_engine.sv
// 4-D hyperchaotic Lorenz integrator (Q16.16, forward Euler), one step per step/done handshake.
// Define CHAOS_SAT_EN to saturate new state values instead of wrapping them.
module chaos_engine #(
  parameter logic [31:0] INIT_X = 32'h0001_0000,
  parameter logic [31:0] INIT_Y = 32'h0001_0000,
  parameter logic [31:0] INIT_Z = 32'h0001_0000,
  parameter logic [31:0] INIT_W = 32'h0001_0000
) (
  input logic   clk,
  input logic   reset,
  chaos_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_CALC, S_UPD, S_DONE} state_t;
  localparam logic signed [31:0] B_Q = 32'sh0002_AAAB;

  state_t state, state_nx;
  logic restart;
  logic [4:0] sh_q;
  logic signed [31:0] w_q, x_q, y_q, z_q;
  logic [12:0] temp_q;
  logic done_q;
  logic [3:0][47:0] prod_q;  // [0]=x*z [1]=x*y [2]=y*z [3]=b*z
  logic signed [47:0] dx_q, dy_q, dz_q, dw_q;
  logic signed [47:0] dx_c, dy_c, dz_c, dw_c;
  logic signed [47:0] xe, ye, ze, we, dyx;
  logic lat_shift, mul_en, calc_en, upd_en;
  logic [1:0] mul_sel;
  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] mul_full, mul_shr;
  logic unused_bits;

  assign restart     = reset | bus.chaos_reset;
  assign unused_bits = ^{bus.chaos_shift[31:5], mul_shr[63:48], ze};

  always_ff @(posedge clk) begin
    if (restart) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.chaos_step) state_nx = S_MUL0;
      S_MUL0:  state_nx = S_MUL1;
      S_MUL1:  state_nx = S_MUL2;
      S_MUL2:  state_nx = S_MUL3;
      S_MUL3:  state_nx = S_CALC;
      S_CALC:  state_nx = S_UPD;
      S_UPD:   state_nx = S_DONE;
      S_DONE:  if (!bus.chaos_step) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    lat_shift = 1'b0;
    mul_en    = 1'b0;
    mul_sel   = 2'd0;
    calc_en   = 1'b0;
    upd_en    = 1'b0;
    case (state)
      S_IDLE:  lat_shift = bus.chaos_step;
      S_MUL0:  begin mul_en = 1'b1; mul_sel = 2'd0; end
      S_MUL1:  begin mul_en = 1'b1; mul_sel = 2'd1; end
      S_MUL2:  begin mul_en = 1'b1; mul_sel = 2'd2; end
      S_MUL3:  begin mul_en = 1'b1; mul_sel = 2'd3; end
      S_CALC:  calc_en = 1'b1;
      S_UPD:   upd_en  = 1'b1;
      default: ;
    endcase
  end

  // Shared multiplier operand select
  always_comb begin
    mul_a = x_q;
    mul_b = z_q;
    case (mul_sel)
      2'd1:    begin mul_a = x_q; mul_b = y_q; end
      2'd2:    begin mul_a = y_q; mul_b = z_q; end
      2'd3:    begin mul_a = B_Q; mul_b = z_q; end
      default: ;
    endcase
  end

  assign mul_full = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
  assign mul_shr  = mul_full >>> 16;

  // a*v and c*v by shift-add: 10v = 8v+2v, 28v = 32v-4v
  always_comb begin
    xe   = {{16{x_q[31]}}, x_q};
    ye   = {{16{y_q[31]}}, y_q};
    ze   = {{16{z_q[31]}}, z_q};
    we   = {{16{w_q[31]}}, w_q};
    dyx  = ye - xe;
    dx_c = (dyx <<< 3) + (dyx <<< 1) + we;
    dy_c = (xe <<< 5) - (xe <<< 2) - ye - $signed(prod_q[0]);
    dz_c = $signed(prod_q[1]) - $signed(prod_q[3]);
    dw_c = -$signed(prod_q[2]) - we;
  end

  function automatic logic [31:0] reduce(input logic signed [48:0] s);
`ifdef CHAOS_SAT_EN
    if (s[48:31] != {18{s[48]}}) return s[48] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
`else
    return s[31:0];
`endif
  endfunction

  function automatic logic [31:0] next_val(input logic signed [31:0] v,
                                           input logic signed [47:0] d,
                                           input logic [4:0] sh);
    logic signed [47:0] dl;
    logic signed [48:0] s;
    dl = d >>> sh;
    s  = $signed({{17{v[31]}}, v}) + $signed({dl[47], dl});
    return reduce(s);
  endfunction

  always_ff @(posedge clk) begin
    if (restart) begin
      x_q    <= INIT_X;
      y_q    <= INIT_Y;
      z_q    <= INIT_Z;
      w_q    <= INIT_W;
      temp_q <= 13'd0;
      done_q <= 1'b0;
      sh_q   <= 5'd0;
    end else begin
      if (lat_shift) sh_q <= bus.chaos_shift[4:0];
      if (mul_en) prod_q[mul_sel] <= mul_shr[47:0];
      if (calc_en) begin
        dx_q <= dx_c;
        dy_q <= dy_c;
        dz_q <= dz_c;
        dw_q <= dw_c;
      end
      if (upd_en) begin
        x_q    <= next_val(x_q, dx_q, sh_q);
        y_q    <= next_val(y_q, dy_q, sh_q);
        z_q    <= next_val(z_q, dz_q, sh_q);
        w_q    <= next_val(w_q, dw_q, sh_q);
        temp_q <= temp_q + 13'd1;
      end
      done_q <= (state_nx == S_DONE);
    end
  end

  assign bus.chaos_done = done_q;
  assign bus.chaos_temp = temp_q;
  assign bus.chaos_x    = x_q;
  assign bus.chaos_y    = y_q;
  assign bus.chaos_z    = z_q;
  assign bus.chaos_w    = w_q;
endmodule

// File: tb/tb_chaos_engine.sv
// Scoreboard bench for chaos_engine: default-IC DUT plus an overflow-IC DUT.
module tb_chaos_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chaos_if a0();
  chaos_if b1();

  chaos_engine u0 (.clk(clk), .reset(reset), .bus(a0));
  chaos_engine #(.INIT_X(32'h7FFF_0000), .INIT_Y(32'h0), .INIT_Z(32'h0), .INIT_W(32'h0))
    u1 (.clk(clk), .reset(reset), .bus(b1));

  typedef struct {
    logic [12:0] temp;
    bit          st;
    logic [31:0] x, y, z, w;
  } exp_t;
  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;
  int mx, my, mz, mw;
  logic [12:0] mtemp;
  logic done_prev = 1'b0;
  localparam longint LMAX = 64'sh7FFF_FFFF;
  localparam longint LMIN = -64'sh8000_0000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int fold(input longint s);
`ifdef CHAOS_SAT_EN
    if (s > LMAX) return int'(LMAX);
    if (s < LMIN) return int'(LMIN);
`endif
    return int'(s);
  endfunction

  task automatic model_reset();
    mx = 32'h0001_0000; my = 32'h0001_0000; mz = 32'h0001_0000; mw = 32'h0001_0000;
    mtemp = 13'd0;
  endtask

  // Reference Euler step using plain 64-bit multiplies
  task automatic model_step(input int sh);
    longint x, y, z, w, pxz, pxy, pyz, pbz, dx, dy, dz, dw;
    x = longint'(mx); y = longint'(my); z = longint'(mz); w = longint'(mw);
    pxz = (x * z) >>> 16;
    pxy = (x * y) >>> 16;
    pyz = (y * z) >>> 16;
    pbz = (longint'(32'sh0002_AAAB) * z) >>> 16;
    dx = 10 * (y - x) + w;
    dy = 28 * x - y - pxz;
    dz = pxy - pbz;
    dw = -pyz - w;
    mx = fold(x + (dx >>> sh));
    my = fold(y + (dy >>> sh));
    mz = fold(z + (dz >>> sh));
    mw = fold(w + (dw >>> sh));
  endtask

  task automatic push_exp(input int sh, input bit st);
    exp_t e;
    if (st) model_step(sh);
    mtemp = mtemp + 13'd1;
    e.temp = mtemp; e.st = st;
    e.x = mx; e.y = my; e.z = mz; e.w = mw;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: one expected record per rising chaos_done
  always @(negedge clk) begin
    if (!reset && a0.chaos_done && !done_prev) begin
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_temp", a0.chaos_temp, e.temp);
        if (e.st) begin
          chk("sb_x", a0.chaos_x, e.x);
          chk("sb_y", a0.chaos_y, e.y);
          chk("sb_z", a0.chaos_z, e.z);
          chk("sb_w", a0.chaos_w, e.w);
        end
      end
    end
    done_prev <= a0.chaos_done;
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!a0.chaos_done && n < 20);
    chk("done_rise", a0.chaos_done, 1);
  endtask

  task automatic step_full(input logic [31:0] sh, input int hold, input bit lat_chk, input bit mid_chg);
    int n;
    a0.chaos_shift = sh;
    a0.chaos_step  = 1'b1;
    push_exp(int'(sh[4:0]), 1'b1);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (mid_chg && n == 2) a0.chaos_shift = 32'h3;
    end while (!a0.chaos_done && n < 20);
    chk("done_rise", a0.chaos_done, 1);
    if (lat_chk) chk("latency", n, 7);
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk("hold_done", a0.chaos_done, 1);
      chk("hold_temp", a0.chaos_temp, mtemp);
      chk("hold_x", a0.chaos_x, mx);
    end
    a0.chaos_step = 1'b0;
    @(negedge clk);
    chk("done_fall", a0.chaos_done, 0);
  endtask

  task automatic quick_step();
    int n;
    a0.chaos_step = 1'b1;
    push_exp(8, 1'b0);
    @(negedge clk);
    a0.chaos_step = 1'b0;
    n = 0;
    while (!a0.chaos_done && n < 20) begin @(negedge clk); n++; end
    if (!a0.chaos_done) chk("quick_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic soft_reset();
    a0.chaos_reset = 1'b1;
    @(negedge clk);
    a0.chaos_reset = 1'b0;
    model_reset();
  endtask

  task automatic chk_init(input string tag);
    chk({tag, "_done"}, a0.chaos_done, 0);
    chk({tag, "_temp"}, a0.chaos_temp, 0);
    chk({tag, "_x"}, a0.chaos_x, 32'h0001_0000);
    chk({tag, "_y"}, a0.chaos_y, 32'h0001_0000);
    chk({tag, "_z"}, a0.chaos_z, 32'h0001_0000);
    chk({tag, "_w"}, a0.chaos_w, 32'h0001_0000);
  endtask

  task automatic chk_s8(input string tag);
    chk({tag, "_x"}, a0.chaos_x, 32'h0001_0100);
    chk({tag, "_y"}, a0.chaos_y, 32'h0001_1A00);
    chk({tag, "_z"}, a0.chaos_z, 32'h0000_FE55);
    chk({tag, "_w"}, a0.chaos_w, 32'h0000_FE00);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    a0.chaos_reset = 1'b0; a0.chaos_step = 1'b0; a0.chaos_shift = 32'd8;
    b1.chaos_reset = 1'b0; b1.chaos_step = 1'b0; b1.chaos_shift = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_init("rst");
    reset = 1'b0;
    @(negedge clk);

    // Overflow: x=32767.0, others 0, dt=1
    b1.chaos_step = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b1.chaos_done && n < 20);
    chk("ovf_done", b1.chaos_done, 1);
`ifdef CHAOS_SAT_EN
    chk("ovf_x", b1.chaos_x, 32'h8000_0000);
    chk("ovf_y", b1.chaos_y, 32'h7FFF_FFFF);
`else
    chk("ovf_x", b1.chaos_x, 32'h8009_0000);
    chk("ovf_y", b1.chaos_y, 32'hFFE4_0000);
`endif
    chk("ovf_z", b1.chaos_z, 0);
    chk("ovf_w", b1.chaos_w, 0);
    b1.chaos_step = 1'b0;

    // Single step from defaults, then held step, then immediate re-request
    step_full(32'd8, 0, 1'b1, 1'b0);
    chk("s1_temp", a0.chaos_temp, 1);
    chk_s8("s1");
    step_full(32'd8, 50, 1'b0, 1'b0);
    chk("s2_temp", a0.chaos_temp, 2);
    step_full(32'd5, 0, 1'b0, 1'b0);

    // Soft reset while in MUL2; step held through reset restarts right after
    a0.chaos_shift = 32'd8;
    a0.chaos_step  = 1'b1;
    repeat (3) @(negedge clk);
    a0.chaos_reset = 1'b1;
    @(negedge clk);
    chk_init("srst");
    repeat (3) @(negedge clk);
    chk("srst_hold_done", a0.chaos_done, 0);
    chk("srst_hold_temp", a0.chaos_temp, 0);
    model_reset();
    push_exp(8, 1'b1);
    a0.chaos_reset = 1'b0;
    wait_done(n);
    chk("srst_latency", n, 7);
    a0.chaos_step = 1'b0;
    @(negedge clk);

    // Shift masking, with a shift change mid-step that must be ignored
    soft_reset();
    step_full(32'hFFFF_FFE8, 0, 1'b0, 1'b1);
    chk_s8("mask");

    // Counter wrap
    soft_reset();
    a0.chaos_shift = 32'd8;
    for (int i = 0; i < 8191; i++) quick_step();
    chk("wrap_8191", a0.chaos_temp, 13'd8191);
    quick_step();
    chk("wrap_0", a0.chaos_temp, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/chaos_engine.md
# chaos_engine

Fabric-side responder for the HPS chaos PIO bank. It integrates a 4-D hyperchaotic Lorenz system (w, x, y, z) in signed Q16.16 using forward Euler, and performs one integration step per HPS request over a 4-phase step/done handshake. Its outputs feed the `pio_chaos_done/temp/w/x/y/z` input PIOs. Its inputs are driven by the `pio_chaos_reset/shift/step` output PIOs.

## Interface
Parameters:
- `INIT_X`, default `32'h0001_0000`: x initial condition (Q16.16, 1.0).
- `INIT_Y`, default `32'h0001_0000`: y initial condition.
- `INIT_Z`, default `32'h0001_0000`: z initial condition.
- `INIT_W`, default `32'h0001_0000`: w initial condition.

Ports:
- `clk` in 1: single clock (the PIO clock domain).
- `reset` in 1: synchronous, active-high reset.
- `chaos_reset` in 1: soft restart from HPS; synchronous, active-high.
- `chaos_step` in 1: step request level.
- `chaos_shift` in 32: bits [4:0] give dt = 2^-shift. Bits [31:5] are ignored.
- `chaos_done` out 1: step-complete level.
- `chaos_temp` out 13: completed-step counter.
- `chaos_w`, `chaos_x`, `chaos_y`, `chaos_z` out 32 each: signed Q16.16 state, registered.

## Operation
- Equations, with a=10, c=28, b=8/3 (`B_Q = 32'h0002_AAAB`), r=-1:
  - dx = a(y−x) + w
  - dy = c·x − y − x·z
  - dz = x·y − b·z
  - dw = −y·z − w
- A single shared 32×32 signed multiplier is used. Each product is the 64-bit result arithmetic-shifted right by 16, kept as 48-bit signed.
- a·v and c·v are computed by shift-add, not by the multiplier.
- Derivatives are 48-bit signed. delta = deriv >>> shift (arithmetic shift, floor).
- Each new state value is computed in 49 bits, then reduced to 32 bits by wrap or saturate (see Configuration).
- FSM states:
  - IDLE: on `chaos_step`=1, latch `shift[4:0]` and go to MUL0.
  - MUL0..MUL3: one product per cycle, in order x·z, x·y, y·z, b·z.
  - CALC: form the four derivatives.
  - UPD: write w/x/y/z, increment `chaos_temp`, go to DONE.
  - DONE: hold `chaos_done`=1 until `chaos_step`=0, then return to IDLE with `chaos_done`=0.
- All four state registers update on the same edge, using only pre-step values.
- `chaos_temp` wraps from 8191 to 0.
- Priority: `reset` > `chaos_reset` > FSM.
- `reset` or `chaos_reset` high, in any state (including mid-step):
  - Go to IDLE, `chaos_done`=0.
  - Load the INIT_* values into the state and clear `chaos_temp` to 0.
  - Any in-flight step is discarded.
- `chaos_step` is ignored while `chaos_reset` is high.
- If `chaos_step` stays high after `chaos_reset` falls, a step starts on the next cycle.

## Timing
- Reset values: `chaos_done`=0, `chaos_temp`=0, w/x/y/z=INIT_*, FSM in IDLE.
- Step latency: `chaos_step` is sampled high in IDLE at edge N. The new state, the incremented `chaos_temp`, and `chaos_done`=1 all become visible after edge N+6 (7 cycles later).
- `chaos_done` falls one cycle after `chaos_step` is sampled low in DONE.
- The next step may be sampled on the cycle after that.
- `chaos_step` held continuously high produces exactly one step, with no retrigger.
- Changes to `chaos_shift` after the step is latched have no effect on the step in progress.
- All outputs come directly from registers.

## Configuration
- `CHAOS_SAT_EN` defined: each 49-bit new-state sum saturates to `32'h7FFF_FFFF` or `32'h8000_0000`.
- `CHAOS_SAT_EN` undefined: the low 32 bits are kept (two's-complement wrap).
- Intermediate product and derivative widths are identical in both builds.

## Test plan
- Reset and soft reset:
  - Stimulus: assert `reset`.
  - Required: `chaos_done`=0, `chaos_temp`=0, all state = `0x00010000`.
  - Stimulus: assert `chaos_reset` while in MUL2.
  - Required: the same values on the next cycle, FSM in IDLE.
- Single step from default initial conditions, shift=8:
  - Required: x=`0x00010100`, y=`0x00011A00`, z=`0x0000FE55`, w=`0x0000FE00`.
  - Required: `chaos_temp`=1, `chaos_done` rises exactly 7 cycles after `chaos_step` is sampled.
- Handshake:
  - Stimulus: hold `chaos_step` high for 50 cycles.
  - Required: exactly one update; `chaos_done` stays 1 until `chaos_step` drops, falls 1 cycle later.
  - Stimulus: immediate re-request.
  - Required: a second step is accepted, `chaos_temp`=2.
- Overflow, INIT_X=`0x7FFF0000`, others 0, shift=0:
  - With `CHAOS_SAT_EN`: y=`0x7FFFFFFF`, x=`0x80000000`.
  - Without `CHAOS_SAT_EN`: y=`0xFFE40000`, x=`0x80090000`.
- Counter wrap:
  - Stimulus: 8192 handshaked steps.
  - Required: `chaos_temp` reads 8191, then 0.
- Shift masking:
  - Stimulus: `chaos_shift`=`0xFFFFFFE8`.
  - Required: result identical to shift=8.
